// File: rtl/cdb_pkg.sv
// Shared definitions for the write-back (CDB) arbiter: sizes, requester ids,
// the buffered result record and the same-destination hazard test.
package cdb_pkg;

  localparam int NUM_REQ   = 8;
  localparam int NUM_PORTS = 2;
  localparam int XLEN      = 32;
  localparam int SRC_W     = 3;

  localparam logic [SRC_W-1:0] SRC_ALU1 = 3'd0;
  localparam logic [SRC_W-1:0] SRC_ALU2 = 3'd1;
  localparam logic [SRC_W-1:0] SRC_ALU3 = 3'd2;
  localparam logic [SRC_W-1:0] SRC_MEM1 = 3'd3;
  localparam logic [SRC_W-1:0] SRC_MEM2 = 3'd4;
  localparam logic [SRC_W-1:0] SRC_MUL  = 3'd5;
  localparam logic [SRC_W-1:0] SRC_DIV  = 3'd6;
  localparam logic [SRC_W-1:0] SRC_JUMP = 3'd7;

  typedef struct packed {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Two real register writes to the same nonzero rd may not leave in one cycle.
  function automatic logic rd_clash(input logic we_a, input logic [4:0] rd_a,
                                    input logic we_b, input logic [4:0] rd_b);
    return we_a && we_b && (rd_a != 5'd0) && (rd_a == rd_b);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of mask at or after start,
// wrapping around, plus a found flag.
module rr_picker #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int cand;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(start) + k;
      if (cand >= N) cand = cand - N;
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Write-back arbiter: one holding entry per functional unit, round-robin grant
// of up to NUM_PORTS entries per cycle onto registered write/broadcast ports.
module cdb_arbiter #(
  parameter int NUM_REQ   = cdb_pkg::NUM_REQ,
  parameter int NUM_PORTS = cdb_pkg::NUM_PORTS,
  parameter int XLEN      = cdb_pkg::XLEN,
  parameter int SRC_W     = cdb_pkg::SRC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*5-1:0]      req_rd,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_PORTS-1:0]      wb_valid,
  output logic [NUM_PORTS-1:0]      wb_we,
  output logic [NUM_PORTS*5-1:0]    wb_rd,
  output logic [NUM_PORTS*XLEN-1:0] wb_data,
  output logic [NUM_PORTS*SRC_W-1:0] wb_src,
  output logic [15:0]               conflict_cnt
);
  import cdb_pkg::*;

  logic [NUM_REQ-1:0] buf_valid;
  logic [NUM_REQ-1:0] buf_we;
  logic [4:0]         buf_rd   [NUM_REQ];
  logic [XLEN-1:0]    buf_data [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr;

  logic [NUM_PORTS-1:0]            pick_found;
  logic [NUM_PORTS-1:0][SRC_W-1:0] pick_idx;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              accept;
  logic                            any_grant;
  logic                            conflict;
  logic [SRC_W-1:0]                last_idx;
  logic [SRC_W-1:0]                next_ptr;

  // Each port searches what earlier ports left: their picks and anything that
  // would write the same rd as a pick are removed from its mask.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [NUM_REQ-1:0] mask;
    logic [SRC_W-1:0]   idx;
    logic               found;

    if (p == 0) begin : g_first
      assign mask = buf_valid;
    end else begin : g_rest
      always_comb begin
        mask = g_port[p-1].mask;
        if (g_port[p-1].found) begin
          mask[g_port[p-1].idx] = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_clash(buf_we[i], buf_rd[i],
                         buf_we[g_port[p-1].idx], buf_rd[g_port[p-1].idx]))
              mask[i] = 1'b0;
          end
        end
      end
    end

    rr_picker #(.N(NUM_REQ), .IDX_W(SRC_W)) u_pick (
      .mask  (mask),
      .start (rr_ptr),
      .idx   (idx),
      .found (found)
    );

    assign pick_idx[p]   = idx;
    assign pick_found[p] = found;
  end

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    last_idx  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_found[p]) begin
        grant[pick_idx[p]] = 1'b1;
        any_grant          = 1'b1;
        last_idx           = pick_idx[p];
      end
    end
  end

  assign next_ptr  = (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + 1'b1;
  assign conflict  = |(buf_valid & ~grant);
  assign req_ready = {NUM_REQ{rst & ~flush}} & (~buf_valid | grant);
  assign accept    = req_valid & req_ready;

  // A granted entry may be refilled in the same cycle it leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= '0;
      buf_we    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else if (flush) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_we[i]    <= req_we[i];
          buf_rd[i]    <= req_rd[5*i +: 5];
          buf_data[i]  <= req_data[XLEN*i +: XLEN];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= '0;
      wb_we    <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_src   <= '0;
    end else if (flush) begin
      wb_valid <= '0;
      wb_we    <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pick_found[p]) begin
          wb_valid[p]               <= 1'b1;
          wb_we[p]                  <= buf_we[pick_idx[p]];
          wb_rd[5*p +: 5]           <= buf_rd[pick_idx[p]];
          wb_data[XLEN*p +: XLEN]   <= buf_data[pick_idx[p]];
          wb_src[SRC_W*p +: SRC_W]  <= pick_idx[p];
        end else begin
          wb_valid[p] <= 1'b0;
          wb_we[p]    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else if (!flush) begin
      if (any_grant) rr_ptr <= next_ptr;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations, then random traffic checked every cycle against a scan model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = NUM_REQ;
  localparam int P  = NUM_PORTS;
  localparam int XL = XLEN;
  localparam int SW = SRC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_we;
  logic [N*5-1:0]    req_rd;
  logic [N*XL-1:0]   req_data;
  logic [P-1:0]      wb_valid;
  logic [P-1:0]      wb_we;
  logic [P*5-1:0]    wb_rd;
  logic [P*XL-1:0]   wb_data;
  logic [P*SW-1:0]   wb_src;
  logic [15:0]       conflict_cnt;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .NUM_PORTS(P), .XLEN(XL), .SRC_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_src       (wb_src),
    .conflict_cnt (conflict_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // FU side: one pending result per unit, held until accepted
  bit        pend   [N];
  wb_entry_t pend_e [N];
  bit        rand_en = 1'b0;

  // Reference model state
  bit          m_bv    [N];
  wb_entry_t   m_e     [N];
  int          m_ptr;
  bit          m_wbv   [P];
  bit          m_wbwe  [P];
  logic [4:0]  m_wbrd  [P];
  logic [XL-1:0] m_wbdata [P];
  int          m_wbsrc [P];
  int          m_cnt;
  int          g_idx   [P];
  int          g_n;
  bit          g_mark  [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 1'b0;
      m_e[i]  = '0;
    end
    for (int p = 0; p < P; p++) begin
      m_wbv[p] = 1'b0; m_wbwe[p] = 1'b0; m_wbrd[p] = '0; m_wbdata[p] = '0; m_wbsrc[p] = 0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  // Walk the buffer in round-robin order, taking entries until the ports run
  // out, skipping any real write whose rd matches one already taken.
  function automatic void compute_grants();
    g_n = 0;
    for (int i = 0; i < N; i++) g_mark[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      int  i;
      bit  clash;
      i = (m_ptr + k) % N;
      if (m_bv[i] && g_n < P) begin
        clash = 1'b0;
        for (int j = 0; j < g_n; j++)
          if (m_e[i].we && m_e[i].rd != 5'd0 && m_e[g_idx[j]].we && m_e[g_idx[j]].rd == m_e[i].rd)
            clash = 1'b1;
        if (!clash) begin
          g_idx[g_n] = i;
          g_n++;
          g_mark[i] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_update();
    bit acc [N];
    bit left_over;
    compute_grants();
    for (int i = 0; i < N; i++)
      acc[i] = req_valid[i] && !flush && (!m_bv[i] || g_mark[i]);
    if (flush) begin
      for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
      for (int p = 0; p < P; p++) begin m_wbv[p] = 1'b0; m_wbwe[p] = 1'b0; end
    end else begin
      for (int p = 0; p < P; p++) begin
        if (p < g_n) begin
          m_wbv[p]    = 1'b1;
          m_wbwe[p]   = m_e[g_idx[p]].we;
          m_wbrd[p]   = m_e[g_idx[p]].rd;
          m_wbdata[p] = m_e[g_idx[p]].data;
          m_wbsrc[p]  = g_idx[p];
        end else begin
          m_wbv[p]  = 1'b0;
          m_wbwe[p] = 1'b0;
        end
      end
      if (g_n > 0) m_ptr = (g_idx[g_n-1] + 1) % N;
      left_over = 1'b0;
      for (int i = 0; i < N; i++) if (m_bv[i] && !g_mark[i]) left_over = 1'b1;
      if (left_over && m_cnt < 65535) m_cnt++;
      for (int i = 0; i < N; i++) begin
        if (g_mark[i]) m_bv[i] = 1'b0;
        if (acc[i]) begin
          m_bv[i] = 1'b1;
          m_e[i]  = pend_e[i];
          pend[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic apply_stimulus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_we[i]            = pend_e[i].we;
      req_rd[i*5 +: 5]     = pend_e[i].rd;
      req_data[i*XL +: XL] = pend_e[i].data;
    end
  endtask

  task automatic check_output();
    logic [N-1:0]    e_rdy;
    logic [P-1:0]    e_v, e_we;
    logic [P*5-1:0]  e_rd;
    logic [P*XL-1:0] e_data;
    logic [P*SW-1:0] e_src;
    compute_grants();
    for (int i = 0; i < N; i++) e_rdy[i] = rst && !flush && (!m_bv[i] || g_mark[i]);
    for (int p = 0; p < P; p++) begin
      e_v[p]              = m_wbv[p];
      e_we[p]             = m_wbwe[p];
      e_rd[p*5 +: 5]      = m_wbrd[p];
      e_data[p*XL +: XL]  = m_wbdata[p];
      e_src[p*SW +: SW]   = SW'(m_wbsrc[p]);
    end
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("wb_valid", 64'(wb_valid), 64'(e_v));
    chk("wb_we", 64'(wb_we), 64'(e_we));
    chk("wb_rd", 64'(wb_rd), 64'(e_rd));
    chk("wb_data", 64'(wb_data), 64'(e_data));
    chk("wb_src", 64'(wb_src), 64'(e_src));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  always @(negedge clk) check_output();

  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    #1;
    if (rand_en) begin
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 55) begin
          pend[i]        = 1'b1;
          pend_e[i].we   = ($urandom_range(0, 3) != 0);
          pend_e[i].rd   = 5'($urandom_range(0, 3));
          pend_e[i].data = $urandom;
        end
      end
    end
    apply_stimulus();
  endtask

  // Reset dropped between edges must clear everything without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_src", 64'(wb_src), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    flush = 1'b0;
    model_reset();
    apply_stimulus();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  function automatic void load(input int i, input bit we, input int rd, input logic [XL-1:0] data);
    pend[i]        = 1'b1;
    pend_e[i].we   = we;
    pend_e[i].rd   = 5'(rd);
    pend_e[i].data = data;
  endfunction

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pend_e[i] = '0; end
    model_reset();
    apply_stimulus();
    #3;
    chk("init_ready", 64'(req_ready), 64'd0);
    chk("init_wb_valid", 64'(wb_valid), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("post_reset_ready", 64'(req_ready), 64'hFF);

    // Single ALU2 result
    load(1, 1'b1, 5, 32'h1234);
    apply_stimulus();
    tick();
    tick();
    chk("t1_valid", 64'(wb_valid), 64'b01);
    chk("t1_rd", 64'(wb_rd[4:0]), 64'd5);
    chk("t1_data", 64'(wb_data[XL-1:0]), 64'h1234);
    chk("t1_src", 64'(wb_src[SW-1:0]), 64'd1);

    // All eight units at once, distinct rd
    do_reset();
    for (int i = 0; i < N; i++) load(i, 1'b1, i + 1, 32'(i * 17));
    apply_stimulus();
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t2_valid", 64'(wb_valid), 64'b11);
      chk("t2_src", 64'(wb_src), 64'({3'(2*c+1), 3'(2*c)}));
    end
    chk("t2_cnt", 64'(conflict_cnt), 64'd3);

    // ALU1 and MEM1 both write x7
    do_reset();
    load(0, 1'b1, 7, 32'hA);
    load(3, 1'b1, 7, 32'hB);
    apply_stimulus();
    tick();
    tick();
    chk("t3_valid_a", 64'(wb_valid), 64'b01);
    chk("t3_src_a", 64'(wb_src[SW-1:0]), 64'd0);
    chk("t3_cnt_a", 64'(conflict_cnt), 64'd1);
    tick();
    chk("t3_valid_b", 64'(wb_valid), 64'b01);
    chk("t3_src_b", 64'(wb_src[SW-1:0]), 64'd3);
    chk("t3_data_b", 64'(wb_data[XL-1:0]), 64'hB);
    chk("t3_cnt_b", 64'(conflict_cnt), 64'd1);

    // JUMP with no register write still retires
    do_reset();
    load(7, 1'b0, 0, 32'h55);
    apply_stimulus();
    tick();
    tick();
    chk("t4_valid", 64'(wb_valid), 64'b01);
    chk("t4_we", 64'(wb_we), 64'b00);
    chk("t4_src", 64'(wb_src[SW-1:0]), 64'd7);

    // MUL streaming one result per cycle
    load(5, 1'b1, 1, 32'd0);
    apply_stimulus();
    tick();
    for (int c = 1; c < 6; c++) begin
      load(5, 1'b1, c + 1, 32'(c));
      apply_stimulus();
      #1;
      chk("t5_ready", 64'(req_ready[5]), 64'd1);
      tick();
      chk("t5_valid", 64'(wb_valid[0]), 64'd1);
      chk("t5_src", 64'(wb_src[SW-1:0]), 64'd5);
      chk("t5_data", 64'(wb_data[XL-1:0]), 64'(c - 1));
    end

    // Flush with three entries held
    load(0, 1'b1, 10, 32'h10);
    load(2, 1'b1, 11, 32'h11);
    load(4, 1'b1, 12, 32'h12);
    apply_stimulus();
    tick();
    flush = 1'b1;
    apply_stimulus();
    #1;
    chk("t6_flush_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    apply_stimulus();
    chk("t6_flush_wb", 64'(wb_valid), 64'd0);
    tick();
    chk("t6_flush_empty", 64'(wb_valid), 64'd0);

    // Reset while results are on the ports
    load(1, 1'b1, 3, 32'h31);
    load(6, 1'b1, 4, 32'h64);
    apply_stimulus();
    tick();
    tick();
    chk("t6_pre_rst", 64'(wb_valid), 64'b11);
    do_reset();

    // Random traffic
    rand_en = 1'b1;
    for (int c = 0; c < 1500; c++) tick();
    do_reset();
    for (int c = 0; c < 1500; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
